// File: rtl/lu_row_mem.sv
// lu_row_mem: matrix row store serving the LU engine's row read/write ports, with host load and dump streams.
module lu_row_mem #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64,
  localparam int RW = SIZE * 2 * WIDTH,
  localparam int AW = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          mat_row_read_addr_valid_i,
  input  logic [AW-1:0] mat_row_read_addr_i,
  output logic [RW-1:0] mat_row_o,
  output logic [AW-1:0] mat_row_addr_o,
  output logic          mat_row_valid_o,
  input  logic          mat_row_wr_valid_i,
  input  logic [AW-1:0] mat_row_wr_addr_i,
  input  logic [RW-1:0] mat_row_wr_i,
  output logic          mat_row_wr_ready_o,
  input  logic          start_load_i,
  input  logic [RW-1:0] host_row_i,
  input  logic          host_row_valid_i,
  output logic          host_row_ready_o,
  input  logic          start_dump_i,
  output logic [RW-1:0] dump_row_o,
  output logic          dump_valid_o,
  input  logic          dump_ready_i,
  output logic          loaded_o,
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;
  localparam int AW1 = AW + 1;
  localparam logic [AW:0]   SZ   = AW1'(SIZE);
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
  state_t state_q, state_d;
  logic [RW-1:0] mem [SIZE];
  logic [AW-1:0] cnt, cnt_nx;
  logic last, ld_acc, wr_acc, dp_acc, rd_req, rd_in, wr_in;
  assign cnt_nx = cnt + 1'b1;
  assign last   = cnt == LAST;
  assign host_row_ready_o   = state_q == LOAD;
  assign mat_row_wr_ready_o = state_q == SERVE;
  assign busy_o = (state_q == LOAD) || (state_q == DUMP);
  assign ld_acc = host_row_ready_o && host_row_valid_i;
  assign wr_acc = mat_row_wr_ready_o && mat_row_wr_valid_i;
  assign dp_acc = (state_q == DUMP) && dump_valid_o && dump_ready_i;
  assign rd_req = (state_q == SERVE) && mat_row_read_addr_valid_i;
  assign rd_in  = {1'b0, mat_row_read_addr_i} < SZ;
  assign wr_in  = {1'b0, mat_row_wr_addr_i} < SZ;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, SERVE: state_d = start_load_i ? LOAD : start_dump_i ? DUMP : state_q;
      LOAD:        state_d = (ld_acc && last) ? SERVE : LOAD;
      DUMP:        state_d = (dp_acc && last) ? IDLE : DUMP;
      default:     state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end
  // Memory has no reset; only completed handshakes write it.
  always_ff @(posedge clk_i)
    if (ld_acc) mem[cnt] <= host_row_i;
    else if (wr_acc && wr_in) mem[mat_row_wr_addr_i] <= mat_row_wr_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt             <= '0;
      loaded_o        <= 1'b0;
      dump_valid_o    <= 1'b0;
      dump_row_o      <= '0;
      mat_row_valid_o <= 1'b0;
      mat_row_addr_o  <= '0;
      mat_row_o       <= '0;
    end else begin
      mat_row_valid_o <= rd_req;
      if (rd_req) begin
        mat_row_addr_o <= mat_row_read_addr_i;
        mat_row_o      <= rd_in ? mem[mat_row_read_addr_i] : '0;
      end
      if (flush_i) begin
        cnt          <= '0;
        loaded_o     <= 1'b0;
        dump_valid_o <= 1'b0;
      end else if (state_d == LOAD && state_q != LOAD) begin
        cnt      <= '0;
        loaded_o <= 1'b0;
      end else if (state_d == DUMP && state_q != DUMP) begin
        cnt <= '0;
      end else if (ld_acc) begin
        cnt <= last ? '0 : cnt_nx;
        if (last) loaded_o <= 1'b1;
      end else if (state_q == DUMP) begin
        if (!dump_valid_o) begin
          dump_valid_o <= 1'b1;
          dump_row_o   <= mem[cnt];
        end else if (dump_ready_i) begin
          if (last) begin
            dump_valid_o <= 1'b0;
            cnt          <= '0;
          end else begin
            cnt        <= cnt_nx;
            dump_row_o <= mem[cnt_nx];
          end
        end
      end
    end
endmodule

// File: tb/tb_lu_row_mem.sv
// tb_lu_row_mem: directed checks of load, engine read/write, dump, flush and async reset.
module tb_lu_row_mem;
  localparam int SIZE = 4, WIDTH = 64, RW = SIZE * 2 * WIDTH, AW = 2;
  logic clk_i = 0, rst_ni = 0, flush_i = 0;
  logic rd_v = 0, wr_v = 0, start_load = 0, start_dump = 0, host_v = 0, dump_rdy = 0;
  logic [AW-1:0] rd_a = '0, wr_a = '0, row_addr;
  logic [RW-1:0] wr_d = '0, host_d = '0, row, dump_row;
  logic row_valid, wr_rdy, host_rdy, dump_valid, loaded, busy;
  logic [RW-1:0] r [4], t [4], w, s0;
  int total = 0, bad = 0;

  lu_row_mem #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .mat_row_read_addr_valid_i(rd_v), .mat_row_read_addr_i(rd_a),
    .mat_row_o(row), .mat_row_addr_o(row_addr), .mat_row_valid_o(row_valid),
    .mat_row_wr_valid_i(wr_v), .mat_row_wr_addr_i(wr_a), .mat_row_wr_i(wr_d),
    .mat_row_wr_ready_o(wr_rdy), .start_load_i(start_load), .host_row_i(host_d),
    .host_row_valid_i(host_v), .host_row_ready_o(host_rdy), .start_dump_i(start_dump),
    .dump_row_o(dump_row), .dump_valid_o(dump_valid), .dump_ready_i(dump_rdy),
    .loaded_o(loaded), .busy_o(busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [RW-1:0] mk(input int id);
    logic [RW-1:0] v;
    for (int k = 0; k < RW / 32; k++) v[k*32 +: 32] = 32'(id) * 32'h0101_0000 + 32'(k) * 32'h11 + 32'h5;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      r[i] = mk(i + 1);
      t[i] = mk(i + 20);
    end
    w  = mk(9);
    s0 = mk(30);
    #12;
    chk("rst_valid", RW'(row_valid), RW'(0));
    chk("rst_row", row, '0);
    chk("rst_dump_valid", RW'(dump_valid), RW'(0));
    chk("rst_busy_loaded", RW'({busy, loaded, host_rdy, wr_rdy}), RW'(0));
    rst_ni = 1;
    step();
    rd_v = 1; rd_a = 0;
    step();
    chk("idle_read_dropped", RW'(row_valid), RW'(0));
    rd_v = 0;
    start_load = 1;
    step();
    start_load = 0;
    chk("load_ready", RW'({host_rdy, busy, loaded}), RW'(3'b110));
    host_v = 1; host_d = r[0];
    step();
    host_v = 0; host_d = s0;
    wr_v = 1; wr_a = 0; wr_d = w;
    chk("load_wr_ready_low", RW'(wr_rdy), RW'(0));
    step();
    wr_v = 0;
    host_v = 1; host_d = r[1];
    step();
    host_d = r[2];
    step();
    chk("loaded_not_yet", RW'(loaded), RW'(0));
    host_d = r[3];
    step();
    host_v = 0;
    chk("loaded_set", RW'(loaded), RW'(1));
    chk("serve_state", RW'({busy, host_rdy, wr_rdy}), RW'(3'b001));
    rd_v = 1; rd_a = 2;
    step();
    chk("rd2_row", row, r[2]);
    chk("rd2_meta", RW'({row_valid, row_addr}), RW'({1'b1, 2'd2}));
    rd_a = 0;
    step();
    chk("rd0_row", row, r[0]);
    rd_a = 1;
    step();
    chk("rd1_row", row, r[1]);
    chk("rd1_meta", RW'({row_valid, row_addr}), RW'({1'b1, 2'd1}));
    rd_a = 3;
    step();
    chk("rd3_row", row, r[3]);
    chk("rd3_meta", RW'({row_valid, row_addr}), RW'({1'b1, 2'd3}));
    rd_v = 0;
    step();
    chk("rd_idle_valid", RW'(row_valid), RW'(0));
    rd_v = 1; rd_a = 1; wr_v = 1; wr_a = 1; wr_d = w;
    step();
    wr_v = 0;
    chk("collide_old", row, r[1]);
    step();
    rd_v = 0;
    chk("collide_new", row, w);
    start_dump = 1;
    step();
    start_dump = 0;
    chk("dump_entry", RW'({dump_valid, busy}), RW'(2'b01));
    step();
    chk("dump_r0_a", dump_row, r[0]);
    chk("dump_valid_up", RW'(dump_valid), RW'(1));
    step();
    chk("dump_r0_b", dump_row, r[0]);
    step();
    chk("dump_r0_c", dump_row, r[0]);
    dump_rdy = 1;
    step();
    chk("dump_r1", dump_row, w);
    step();
    chk("dump_r2", dump_row, r[2]);
    step();
    chk("dump_r3", dump_row, r[3]);
    chk("dump_r3_valid", RW'(dump_valid), RW'(1));
    step();
    dump_rdy = 0;
    chk("dump_done", RW'({dump_valid, busy}), RW'(0));
    flush_i = 1; start_load = 1;
    step();
    flush_i = 0; start_load = 0;
    chk("flush_beats_start", RW'(busy), RW'(0));
    start_load = 1;
    step();
    start_load = 0;
    host_v = 1; host_d = s0;
    step();
    host_d = s0;
    step();
    host_v = 0;
    flush_i = 1;
    step();
    flush_i = 0;
    chk("flush_idle", RW'({busy, loaded, host_rdy}), RW'(0));
    start_load = 1;
    step();
    start_load = 0;
    for (int i = 0; i < 4; i++) begin
      host_v = 1; host_d = t[i];
      step();
    end
    host_v = 0;
    chk("reload_loaded", RW'(loaded), RW'(1));
    rd_v = 1; rd_a = 0;
    step();
    chk("reload_row0", row, t[0]);
    rd_a = 3;
    step();
    rd_v = 0;
    chk("reload_row3", row, t[3]);
    start_dump = 1;
    step();
    start_dump = 0;
    step();
    chk("pre_rst_dump", RW'(dump_valid), RW'(1));
    #2 rst_ni = 0;
    #1;
    chk("arst_dump_valid", RW'(dump_valid), RW'(0));
    chk("arst_dump_row", dump_row, '0);
    chk("arst_row", row, '0);
    chk("arst_flags", RW'({busy, loaded, host_rdy, wr_rdy, row_valid, row_addr}), RW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
